// File: rtl/set_pkg.sv
// Shared definitions for SET circle-count engine wrappers: operand widths,
// mode encodings and the job-arbiter state enum.
package set_pkg;

  localparam int CENT_W = 24;
  localparam int RAD_W  = 12;
  localparam int CAND_W = 8;

  localparam logic [1:0] SET_MODE_A   = 2'd0;
  localparam logic [1:0] SET_MODE_AND = 2'd1;
  localparam logic [1:0] SET_MODE_XOR = 2'd2;
  localparam logic [1:0] SET_MODE_TWO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request after ptr wins,
// reported both as a one-hot grant and as an encoded index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] j;

  // Scan ptr+1 .. ptr+N so the previous winner has lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/set_job_arbiter.sv
// Shares one SET engine among N_REQ requesters: round-robin grant, single-cycle
// launch, watchdog-guarded run, and a tagged response channel.
//
//   state     | meaning
//   ST_IDLE   | waiting for any req_valid; grant and latch operands
//   ST_LAUNCH | waiting for engine idle, then pulse set_en
//   ST_RUN    | engine working; watchdog counting
//   ST_RESP   | response presented until rsp_ready
module set_job_arbiter
  import set_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [24*N_REQ-1:0]     req_central,
  input  logic [12*N_REQ-1:0]     req_radius,
  input  logic [2*N_REQ-1:0]      req_mode,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [7:0]              rsp_candidate,
  output logic                    rsp_err,
  output logic                    set_en,
  output logic [23:0]             set_central,
  output logic [11:0]             set_radius,
  output logic [1:0]              set_mode,
  input  logic                    set_busy,
  input  logic                    set_valid,
  input  logic [7:0]              set_candidate
);

  localparam int WD_W = $clog2(TIMEOUT);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CENT_W-1:0]  central_q, central_d;
  logic [RAD_W-1:0]   radius_q, radius_d;
  logic [1:0]         mode_q, mode_d;
  logic [CAND_W-1:0]  cand_q, cand_d;
  logic               err_q, err_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;

  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [CENT_W-1:0]  sel_central;
  logic [RAD_W-1:0]   sel_radius;
  logic [1:0]         sel_mode;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    sel_central = '0;
    sel_radius  = '0;
    sel_mode    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_central = req_central[CENT_W*i +: CENT_W];
        sel_radius  = req_radius[RAD_W*i +: RAD_W];
        sel_mode    = req_mode[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    cand_d    = cand_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    set_en    = 1'b0;
    rsp_valid = 1'b0;
    req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (gnt_any) begin
          rr_ptr_d  = gnt_idx;
          id_d      = gnt_idx;
          central_d = sel_central;
          radius_d  = sel_radius;
          mode_d    = sel_mode;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // A busy left over from a previous job must not swallow this start.
        if (!set_busy) begin
          set_en  = 1'b1;
          wdog_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wdog_d = wdog_q + WD_W'(1);
        if (set_valid) begin
          cand_d  = set_candidate;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          cand_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= ID_W'(N_REQ - 1);
      id_q      <= '0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      cand_q    <= '0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      cand_q    <= cand_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign rsp_id        = id_q;
  assign rsp_candidate = cand_q;
  assign rsp_err       = err_q;
  assign set_central   = central_q;
  assign set_radius    = radius_q;
  assign set_mode      = mode_q;

endmodule

// File: tb/tb_set_job_arbiter.sv
// Scoreboard bench for set_job_arbiter behind a behavioural 64-cycle SET engine.
module tb_set_job_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [95:0] req_central = '0;
  logic [47:0] req_radius = '0;
  logic [7:0]  req_mode = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_candidate;
  logic        rsp_err;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;

  logic        eng_busy, eng_valid;
  logic [7:0]  eng_cand;
  int          eng_cnt;
  logic        force_busy = 1'b0;
  logic        stub = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_pulses = 0;

  typedef struct { int id; int cand; int err; } rsp_t;
  rsp_t exp_rsp[$];
  int   exp_gnt[$];

  set_job_arbiter #(.N_REQ(4), .ID_W(2), .TIMEOUT(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_central(req_central), .req_radius(req_radius), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_candidate(rsp_candidate), .rsp_err(rsp_err),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int set_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    int n, a, b, e;
    n = 0;
    for (int x = 1; x <= 8; x++)
      for (int y = 1; y <= 8; y++) begin
        a = ((x - int'(c[23:20]))**2 + (y - int'(c[19:16]))**2 <= int'(r[11:8])**2) ? 1 : 0;
        b = ((x - int'(c[15:12]))**2 + (y - int'(c[11:8]))**2  <= int'(r[7:4])**2)  ? 1 : 0;
        e = ((x - int'(c[7:4]))**2   + (y - int'(c[3:0]))**2   <= int'(r[3:0])**2)  ? 1 : 0;
        case (m)
          2'd0: n += a;
          2'd1: n += a & b;
          2'd2: n += a ^ b;
          default: n += ((a + b + e) == 2) ? 1 : 0;
        endcase
      end
    return n;
  endfunction

  // Engine: busy for 64 cycles after set_en, then a one-cycle done pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt <= 0; eng_busy <= 1'b0; eng_valid <= 1'b0; eng_cand <= '0;
    end else begin
      eng_valid <= 1'b0;
      if (set_en) begin
        eng_cnt  <= 64;
        eng_busy <= 1'b1;
        eng_cand <= 8'(set_count(set_central, set_radius, set_mode));
      end else if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          eng_busy  <= 1'b0;
          eng_valid <= 1'b1;
        end
      end
    end
  end

  assign set_busy      = eng_busy | force_busy;
  assign set_valid     = eng_valid & ~stub;
  assign set_candidate = eng_cand;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops grant and response expectations whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (set_en) en_pulses++;
      if (req_ready != 4'b0) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", {28'b0, req_ready}, 32'h0);
        else chk("grant", {28'b0, req_ready}, exp_gnt.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", {30'b0, rsp_id}, 32'hFFFF);
        else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_id", {30'b0, rsp_id}, e.id);
          chk("rsp_candidate", {24'b0, rsp_candidate}, e.cand);
          chk("rsp_err", {31'b0, rsp_err}, e.err);
        end
      end
    end
  end

  task automatic expect_job(input int id, input int cand, input int err);
    rsp_t r;
    r.id = id; r.cand = cand; r.err = err;
    exp_gnt.push_back(1 << id);
    exp_rsp.push_back(r);
  endtask

  task automatic set_job(input int i, input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    req_central[24*i +: 24] = c;
    req_radius[12*i +: 12]  = r;
    req_mode[2*i +: 2]      = m;
  endtask

  task automatic wait_grant(output int g, output int c);
    g = -1; c = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        c = cyc;
        return;
      end
    end
    chk("grant_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c = cyc;
        return;
      end
    end
    chk("rsp_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int g, c0, c1, e0;
    for (int i = 0; i < 4; i++) set_job(i, 24'h440000, 12'h200, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("reset_set_en", {31'b0, set_en}, 0);
    chk("reset_set_central", {8'b0, set_central}, 0);
    rst = 1'b0;

    // All four requesters at once; req1 stays asserted after its first grant.
    for (int i = 0; i < 4; i++) expect_job(i, 13, 0);
    expect_job(1, 13, 0);
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, c0);
      if (g < 0) break;
      @(posedge clk); #1;
      if (n != 1) req_valid[g] = 1'b0;
    end
    wait_rsp(c1);
    @(posedge clk); #1;

    // Single job with latency and operand-hold checks.
    expect_job(0, 13, 0);
    req_valid = 4'b0001;
    wait_grant(g, c0);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    chk("held_central", {8'b0, set_central}, 32'h440000);
    chk("held_radius", {20'b0, set_radius}, 32'h200);
    wait_rsp(c1);
    chk("latency", c1 - c0, 67);
    @(posedge clk); #1;

    // Back-pressure in RESP with another requester waiting.
    set_job(3, 24'h444400, 12'h210, 2'd1);
    expect_job(3, 5, 0);
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    wait_grant(g, c0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(c1);
    req_valid = 4'b0001;
    expect_job(0, 13, 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n % 5 == 0) begin
        chk("hold_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("hold_rsp_id", {30'b0, rsp_id}, 3);
        chk("hold_rsp_cand", {24'b0, rsp_candidate}, 5);
        chk("hold_set_en", {31'b0, set_en}, 0);
        chk("hold_req_ready", {28'b0, req_ready}, 0);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("release_idle_grant", {28'b0, req_ready}, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(c1);
    @(posedge clk); #1;

    // Stale busy during LAUNCH; corner circle clipped by the grid.
    set_job(1, 24'h110000, 12'h200, 2'd0);
    expect_job(1, 6, 0);
    force_busy = 1'b1;
    req_valid = 4'b0010;
    wait_grant(g, c0);
    @(posedge clk); #1;
    req_valid = '0;
    e0 = en_pulses;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("busy_no_en", {31'b0, set_en}, 0);
      @(posedge clk); #1;
    end
    force_busy = 1'b0;
    @(negedge clk);
    chk("en_after_busy", {31'b0, set_en}, 1);
    wait_rsp(c1);
    chk("en_pulse_count", en_pulses - e0, 1);
    @(posedge clk); #1;

    // Hung engine -> watchdog error response.
    stub = 1'b1;
    expect_job(2, 0, 1);
    req_valid = 4'b0100;
    wait_grant(g, c0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(c1);
    chk("timeout_latency", c1 - c0, 130);
    @(posedge clk); #1;
    stub = 1'b0;

    // Reset mid-run drops the job silently.
    exp_gnt.push_back(1);
    req_valid = 4'b0001;
    wait_grant(g, c0);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (31) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_set_en", {31'b0, set_en}, 0);
    chk("rst_outputs", {set_central, set_mode, rsp_id, rsp_err, 3'b0}, 0);
    chk("rst_radius_cand", {12'b0, set_radius, rsp_candidate}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_job(2, 13, 0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("post_rst_grant", {28'b0, req_ready}, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(c1);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);

    chk("grants_left", exp_gnt.size(), 0);
    chk("rsps_left", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
